// File: rtl/risc_v_lsu.sv
// RV32 load/store unit: sequences byte-addressed loads/stores onto a word-addressed memory,
// using read-modify-write for sub-word stores and two word accesses for misaligned ones.
module risc_v_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Handshakes: a request transfers on the rising edge where req_valid & req_ready, a
  // response on the edge where resp_valid & resp_ready; valid is never withdrawn early.
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

  state_t                  state, state_next;
  logic                    store_q, split_q;
  logic [2:0]              funct3_q;
  logic [ADDR_WIDTH-1:0]   w0_q, w1;
  logic [1:0]              off_q;
  logic [DATA_WIDTH-1:0]   wdata_q, buf0, buf1;

  logic                    accept;
  logic                    in_illegal, in_split, in_aligned_sw;
  logic [1:0]              in_off;
  logic [3:0]              size_mask;
  logic [7:0]              byte_mask;
  logic [2*DATA_WIDTH-1:0] bit_mask, data64, merged;
  logic [DATA_WIDTH-1:0]   rd_word0, rd_word1, load_word, load_val;

  assign accept = req_valid & req_ready;
  assign in_off = req_addr[1:0];
  assign w1     = w0_q + ADDR_WIDTH'(1);

  always_comb begin
    in_illegal    = req_store ? (req_funct3 > 3'd2)
                              : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    in_split      = (req_funct3[1:0] == 2'd1 && in_off == 2'd3) ||
                    (req_funct3[1:0] == 2'd2 && in_off != 2'd0);
    in_aligned_sw = req_store && req_funct3 == 3'd2 && in_off == 2'd0;
  end

  // Words just being read bypass the buffers so the load result can be registered on DONE entry.
  assign rd_word0 = (state == RD0) ? mem_rdata : buf0;
  assign rd_word1 = (state == RD1) ? mem_rdata : buf1;

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    byte_mask = {4'b0000, size_mask} << off_q;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    data64    = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
    merged    = ({buf1, buf0} & ~bit_mask) | (data64 & bit_mask);
    load_word = DATA_WIDTH'({rd_word1, rd_word0} >> {off_q, 3'b000});
    case (funct3_q)
      3'd0:    load_val = {{(DATA_WIDTH-8){load_word[7]}}, load_word[7:0]};
      3'd1:    load_val = {{(DATA_WIDTH-16){load_word[15]}}, load_word[15:0]};
      3'd2:    load_val = load_word;
      3'd4:    load_val = {{(DATA_WIDTH-8){1'b0}}, load_word[7:0]};
      3'd5:    load_val = {{(DATA_WIDTH-16){1'b0}}, load_word[15:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = in_illegal ? DONE : (in_aligned_sw ? WR0 : RD0);
      end
      RD0: begin
        mem_addr   = w0_q;
        state_next = split_q ? RD1 : (store_q ? WR0 : DONE);
      end
      RD1: begin
        mem_addr   = w1;
        state_next = store_q ? WR0 : DONE;
      end
      WR0: begin
        mem_write  = 1'b1;
        mem_addr   = w0_q;
        mem_wdata  = merged[DATA_WIDTH-1:0];
        state_next = split_q ? WR1 : DONE;
      end
      WR1: begin
        mem_write  = 1'b1;
        mem_addr   = w1;
        mem_wdata  = merged[2*DATA_WIDTH-1:DATA_WIDTH];
        state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset silences the memory port and the handshakes in the same cycle it is asserted.
    if (rst) begin
      state_next = IDLE;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      split_q    <= 1'b0;
      funct3_q   <= '0;
      w0_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      buf0       <= '0;
      buf1       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        store_q    <= req_store;
        split_q    <= in_split;
        funct3_q   <= req_funct3;
        w0_q       <= req_addr[ADDR_WIDTH+1:2];
        off_q      <= in_off;
        wdata_q    <= req_wdata;
        resp_err   <= in_illegal;
        resp_rdata <= '0;
      end
      if (state == RD0) buf0 <= mem_rdata;
      if (state == RD1) buf1 <= mem_rdata;
      if (!store_q && ((state == RD0 && !split_q) || state == RD1)) resp_rdata <= load_val;
    end
  end

endmodule
